// File: rtl/ser_pkg.sv
// Shared constants and types for the serial link receive path.
// Default framing values are also used by the serializer side.
package ser_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int          DEF_WORD_W      = 8;
  localparam int          DEF_FRAME_WORDS = 8;
  localparam logic [7:0]  DEF_SYNC_WORD   = 8'hA7;

  // Saturating 8-bit increment for error counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ser_align_fsm.sv
// Alignment state machine: hunts for the sync word, verifies it over
// LOCK_COUNT frames, and drops lock after LOSS_COUNT consecutive bad syncs.
module ser_align_fsm
  import ser_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2
) (
  input  logic   clkin,
  input  logic   reset_n,
  input  logic   sync_match,
  input  logic   at_sync_boundary,
  input  logic   hunt_match,
  output state_t state,
  output logic   locked
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] LOSS_LAST = MW'(LOSS_COUNT - 1);

  state_t        state_r;
  logic [GW-1:0] good_cnt_r;
  logic [MW-1:0] miss_cnt_r;
  logic          locked_r;

  // State, good/miss counters and the registered lock flag.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state_r    <= HUNT;
      good_cnt_r <= '0;
      miss_cnt_r <= '0;
      locked_r   <= 1'b0;
    end else begin
      case (state_r)
        HUNT: begin
          if (hunt_match) begin
            good_cnt_r <= GW'(1);
            if (LOCK_COUNT == 1) begin
              state_r    <= LOCKED;
              miss_cnt_r <= '0;
              locked_r   <= 1'b1;
            end else begin
              state_r <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (at_sync_boundary) begin
            if (!sync_match) begin
              state_r <= HUNT;
            end else if (good_cnt_r == LOCK_LAST) begin
              state_r    <= LOCKED;
              miss_cnt_r <= '0;
              locked_r   <= 1'b1;
            end else begin
              good_cnt_r <= good_cnt_r + GW'(1);
            end
          end
        end
        LOCKED: begin
          if (at_sync_boundary) begin
            if (sync_match) begin
              miss_cnt_r <= '0;
            end else if (miss_cnt_r == LOSS_LAST) begin
              state_r    <= HUNT;
              miss_cnt_r <= '0;
              locked_r   <= 1'b0;
            end else begin
              miss_cnt_r <= miss_cnt_r + MW'(1);
            end
          end
        end
        default: begin
          state_r  <= HUNT;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign state  = state_r;
  assign locked = locked_r;

endmodule

// File: rtl/ser_deser.sv
// Serial-to-parallel receiver: shifts in one bit per clock, tracks word and
// frame position, and emits data words once the alignment FSM reports lock.
module ser_deser
  import ser_pkg::*;
#(
  parameter int                 WORD_W      = DEF_WORD_W,
  parameter logic [WORD_W-1:0]  SYNC_WORD   = WORD_W'(DEF_SYNC_WORD),
  parameter int                 FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int                 LOCK_COUNT  = 3,
  parameter int                 LOSS_COUNT  = 2
) (
  input  logic              clkin,
  input  logic              reset_n,
  input  logic              sdata,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              frame_start,
  output logic              locked,
  output logic [7:0]        sync_err_cnt
);

  localparam int BW = $clog2(WORD_W);
  localparam int IW = $clog2(FRAME_WORDS);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_WORDS - 1);

  // The oldest bit shifts out and is never looked at again, so only the
  // low WORD_W-1 bits of the shift register are stored.
  logic [WORD_W-2:0] sr_r;
  logic [WORD_W-1:0] sr_next_s;
  logic [BW-1:0]     bit_cnt_r;
  logic [IW-1:0]     word_idx_r;
  logic              boundary_s;
  logic              at_sync_boundary_s;
  logic              sync_match_s;
  state_t            state_s;
  logic              locked_s;
  logic [WORD_W-1:0] word_r;
  logic              word_valid_r;
  logic              frame_start_r;
  logic [7:0]        sync_err_cnt_r;

  // Next shift-register value and word/sync boundary decode.
  always_comb begin
    sr_next_s          = {sr_r, sdata};
    boundary_s         = (bit_cnt_r == BIT_LAST);
    at_sync_boundary_s = boundary_s && (word_idx_r == '0);
    sync_match_s       = (sr_next_s == SYNC_WORD);
  end

  ser_align_fsm #(
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_COUNT (LOSS_COUNT)
  ) u_fsm (
    .clkin            (clkin),
    .reset_n          (reset_n),
    .sync_match       (sync_match_s),
    .at_sync_boundary (at_sync_boundary_s),
    .hunt_match       (sync_match_s),
    .state            (state_s),
    .locked           (locked_s)
  );

  // Shift register runs in every state.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      sr_r <= '0;
    end else begin
      sr_r <= sr_next_s[WORD_W-2:0];
    end
  end

  // Bit and word position; a hunt match puts us on bit 0 of word 1.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      bit_cnt_r  <= '0;
      word_idx_r <= '0;
    end else if (state_s == HUNT) begin
      if (sync_match_s) begin
        bit_cnt_r  <= '0;
        word_idx_r <= IW'(1);
      end
    end else if (boundary_s) begin
      bit_cnt_r  <= '0;
      word_idx_r <= (word_idx_r == IDX_LAST) ? '0 : word_idx_r + IW'(1);
    end else begin
      bit_cnt_r <= bit_cnt_r + BW'(1);
    end
  end

  // Data word output; only data boundaries in LOCKED produce a strobe.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      word_r        <= '0;
      word_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if ((state_s == LOCKED) && boundary_s && (word_idx_r != '0)) begin
      word_r        <= sr_next_s;
      word_valid_r  <= 1'b1;
      frame_start_r <= (word_idx_r == IW'(1));
    end else begin
      word_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  // Sync mismatch counter, saturating, cleared only by reset.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      sync_err_cnt_r <= 8'd0;
    end else if (((state_s == VERIFY) || (state_s == LOCKED)) &&
                 at_sync_boundary_s && !sync_match_s) begin
      sync_err_cnt_r <= sat_inc8(sync_err_cnt_r);
    end
  end

  assign word         = word_r;
  assign word_valid   = word_valid_r;
  assign frame_start  = frame_start_r;
  assign locked       = locked_s;
  assign sync_err_cnt = sync_err_cnt_r;

endmodule
